// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, FSM states and op-class helpers
// Also imported by the ALU-control decoder, so code values must stay in sync with it.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_op_t;

    // case rather than == so an X code resolves to "not legal" instead of X
    function automatic logic is_legal(input logic [3:0] code);
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SLT,
            ALU_SLTU, ALU_SUB, ALU_XOR, ALU_SRL, ALU_SRA: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [3:0] code);
        case (code)
            ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic shift_op_t shift_op(input logic [3:0] code);
        case (code)
            ALU_SRL: return SH_SRL;
            ALU_SRA: return SH_SRA;
            default: return SH_SLL;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - issue/result handshake bundle of the execute-stage ALU
interface alu_exec_unit_if #(
    parameter int XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

endinterface

// File: rtl/alu_serial_shifter.sv
// rtl/alu_serial_shifter.sv - 1-bit-per-cycle shifter for sll/srl/sra
// The load edge already performs the first step, so done_o rises shamt-1 cycles after load.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  shift_op_t       op_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [SHW-1:0]  shamt_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] data_q,  data_d;
    logic [SHW-1:0]  count_q, count_d;
    shift_op_t       op_q,    op_d;
    logic            busy_q,  busy_d;

    function automatic logic [XLEN-1:0] step(input shift_op_t op, input logic [XLEN-1:0] d);
        case (op)
            SH_SRL:  return {1'b0, d[XLEN-1:1]};
            SH_SRA:  return {d[XLEN-1], d[XLEN-1:1]};
            default: return {d[XLEN-2:0], 1'b0};
        endcase
    endfunction

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        op_d    = op_q;
        busy_d  = busy_q;
        if (load_i) begin
            data_d  = step(op_i, data_i);
            count_d = shamt_i - SHW'(1);
            op_d    = op_i;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (count_q != '0) begin
                data_d  = step(op_q, data_q);
                count_d = count_q - SHW'(1);
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
            op_q    <= SH_SLL;
            busy_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (count_q == '0);
    assign data_o = data_q;

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU: single-cycle logic/arith/compare, serial shifts
// All handshake outputs come straight from flops; in_ready is high only while idle.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    alu_exec_unit_if.slave  bus
);

    localparam int SHW = $clog2(XLEN);

    alu_state_t      state_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            illegal_q;
    logic            out_valid_q;
    logic            in_ready_q;

    logic            accept;
    logic            legal;
    logic            shift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_d;
    logic            sh_load;
    logic            sh_busy;
    logic            sh_done;
    logic [XLEN-1:0] sh_data;

    assign accept  = bus.in_valid & in_ready_q;
    assign legal   = is_legal(bus.alu_ctrl);
    assign shift   = is_shift(bus.alu_ctrl);
    assign shamt   = bus.op_b[SHW-1:0];
    assign sh_load = accept & legal & shift & (shamt != '0);

    // shift codes land here only for shamt==0, where the answer is op_a unchanged
    always_comb begin
        alu_d = '0;
        case (bus.alu_ctrl)
            ALU_AND:  alu_d = bus.op_a & bus.op_b;
            ALU_OR:   alu_d = bus.op_a | bus.op_b;
            ALU_XOR:  alu_d = bus.op_a ^ bus.op_b;
            ALU_ADD:  alu_d = bus.op_a + bus.op_b;
            ALU_SUB:  alu_d = bus.op_a - bus.op_b;
            ALU_SLT:  alu_d = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
            ALU_SLTU: alu_d = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
            ALU_SLL, ALU_SRL, ALU_SRA: alu_d = bus.op_a;
            default:  alu_d = '0;
        endcase
    end

    alu_serial_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load),
        .op_i    (shift_op(bus.alu_ctrl)),
        .data_i  (bus.op_a),
        .shamt_i (shamt),
        .busy_o  (sh_busy),
        .done_o  (sh_done),
        .data_o  (sh_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (!legal) begin
                            result_q    <= '0;
                            zero_q      <= 1'b1;
                            illegal_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (shift && (shamt != '0)) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            result_q    <= alu_d;
                            zero_q      <= (alu_d == '0);
                            illegal_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (sh_busy && sh_done) begin
                        result_q    <= sh_data;
                        zero_q      <= (sh_data == '0);
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit with a behavioural reference model
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    bit   force_low = 1'b0;
    bit   seen      = 1'b0;
    logic [3:0] codes [0:9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sh;
        sh    = int'(b % 32);
        e.ill = 1'b0;
        e.lat = 1;
        e.acc = 0;
        case (c)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0111: e.res = a ^ b;
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0100: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0101: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b0011: begin e.res = a << sh; e.lat = 1 + sh; end
            4'b1000: begin e.res = a >> sh; e.lat = 1 + sh; end
            4'b1010: begin e.res = $unsigned($signed(a) >>> sh); e.lat = 1 + sh; end
            default: begin e.res = 32'd0; e.ill = 1'b1; end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.alu_ctrl = c;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=in_ready_low required=in_ready_high");
            bus.in_valid = 1'b0;
            return;
        end
        e     = model(c, a, b);
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.alu_ctrl = 4'($urandom);
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (bus.out_valid) begin
                check("in_ready_while_valid", 32'(bus.in_ready), 32'd0);
                if (!seen) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out_valid actual=1 required=0 (t=%0t)", $time);
                    end else begin
                        cur = sb.pop_front();
                        check("result",  bus.result,          cur.res);
                        check("zero",    32'(bus.zero),       32'(cur.zero));
                        check("illegal", 32'(bus.illegal),    32'(cur.ill));
                        check("latency", 32'(cyc - cur.acc),  32'(cur.lat));
                    end
                    seen = 1'b1;
                end else begin
                    check("result_held", bus.result, cur.res);
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        logic [3:0]  c;
        logic [31:0] a, b, b2;
        codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLL,
                  ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA};
        bus.in_valid = 1'b0;
        bus.alu_ctrl = 4'd0;
        bus.op_a     = 32'd0;
        bus.op_b     = 32'd0;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    bus.result,         32'd0);
        check("rst_zero",      32'(bus.zero),      32'd0);
        check("rst_illegal",   32'(bus.illegal),   32'd0);
        rst = 1'b0;

        issue(4'b0010, 32'd5, 32'd7);
        issue(4'b0110, 32'h1234, 32'h1234);
        issue(4'b0101, 32'd1, 32'hFFFF_FFFF);
        issue(4'b0100, 32'd1, 32'hFFFF_FFFF);
        issue(4'b1010, 32'h8000_0000, 32'd4);
        issue(4'b1000, 32'h8000_0000, 32'd4);
        issue(4'b0011, 32'h0000_0003, 32'd31);
        issue(4'b1000, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
        issue(4'b1111, 32'h1234_5678, 32'h9);
        issue(4'b0010, 32'd0, 32'd0);
        issue(4'b1001, 32'h1, 32'h1);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
        issue(4'b1010, 32'h7000_0001, 32'd1);
        drain();

        force_low = 1'b1;
        issue(4'b0111, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
        @(negedge clk);
        bus.alu_ctrl = 4'b0001;
        bus.op_a     = 32'h0000_00F0;
        bus.op_b     = 32'h0000_0F00;
        bus.in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        force_low = 1'b0;
        issue(4'b0001, 32'h0000_00F0, 32'h0000_0F00);
        drain();

        issue(4'b0011, 32'h0000_0001, 32'd20);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_result",    bus.result,         32'd0);
        check("midrst_zero",      32'(bus.zero),      32'd0);
        check("midrst_illegal",   32'(bus.illegal),   32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        repeat (250) begin
            if ($urandom_range(0, 7) == 0) c = 4'($urandom_range(0, 15));
            else                           c = codes[$urandom_range(0, 9)];
            a  = $urandom;
            b  = $urandom;
            b2 = $urandom;
            if ($urandom_range(0, 5) == 0) b = a;
            if ($urandom_range(0, 5) == 0) a = {b2[0], 31'd0} | (a & 32'h0000_00FF);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(c, a, b);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
